// File: rtl/final_add_seq.sv
// ---------------------------------------------------------------------------
// final_add_seq -- sequencer for the 14-bit final adder stage.
//
// Each accepted 28-bit partial-sum vector is split into its even-bit operand
// A and odd-bit operand B and reduced by adder_final to S = (A + B) mod 2^14.
// S values are accumulated with saturation over `passes` beats to form one
// output word. `outputs` words make up a job, and the last word is tagged.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_start               one-cycle job start (honoured only when idle)
//   cfg_passes/cfg_outputs  beats per word / words per job (0 means 1)
//   ps_valid/ps_ready       upstream handshake, ps_data carries the vector
//   out_valid/out_ready     downstream handshake
//   out_data/out_last       accumulated word and end-of-job marker
//   busy, done, ovf         status: not idle / completion pulse / sticky clamp
// ---------------------------------------------------------------------------

// Reduces one packed vector. Bits [2k+1:2k] hold the operand pair for bit k.
module adder_final (
  input  logic [27:0] vec_i,
  output logic [13:0] sum_o
);
  logic [13:0] a_op;
  logic [13:0] b_op;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    a_op = '0;
    b_op = '0;
    for (int k = 0; k < 14; k++) begin
      a_op[k] = vec_i[2*k];
      b_op[k] = vec_i[2*k+1];
    end
    // The carry out of bit 13 is intentionally dropped.
    sum_o = a_op + b_op;
  end
endmodule

module final_add_seq #(
  parameter int PASS_W = 8,
  parameter int CNT_W  = 12,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic [CNT_W-1:0]  cfg_outputs,
  input  logic              ps_valid,
  output logic              ps_ready,
  input  logic [27:0]       ps_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e              state_q;
  logic [PASS_W-1:0]   passes_q;
  logic [CNT_W-1:0]    outputs_q;
  logic [PASS_W-1:0]   pass_cnt_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic                out_valid_q;
  logic [ACC_W-1:0]    out_data_q;
  logic                out_last_q;
  logic                done_q;
  logic                ovf_q;

  logic [13:0]         beat_sum;
  logic [ACC_W:0]      acc_sum;
  logic [ACC_W-1:0]    acc_sat;
  logic                sat_hit;
  logic                ps_fire;
  logic                out_fire;
  logic                last_pass;
  logic                last_out;
  logic [PASS_W-1:0]   passes_eff;
  logic [CNT_W-1:0]    outputs_eff;

  adder_final u_adder_final (
    .vec_i (ps_data),
    .sum_o (beat_sum)
  );

  always_comb begin
    // One spare bit catches the overflow that triggers the clamp.
    acc_sum     = {1'b0, acc_q} + (ACC_W+1)'(beat_sum);
    sat_hit     = acc_sum[ACC_W];
    acc_sat     = sat_hit ? '1 : acc_sum[ACC_W-1:0];
    passes_eff  = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
    outputs_eff = (cfg_outputs == '0) ? CNT_W'(1) : cfg_outputs;
    last_pass   = (pass_cnt_q == passes_q - PASS_W'(1));
    last_out    = (out_cnt_q == outputs_q - CNT_W'(1));
  end

  // A new vector may enter whenever the output slot is empty or draining this
  // cycle, which keeps one beat per cycle under a ready sink.
  assign ps_ready  = (state_q == ST_ACC) && (!out_valid_q || out_ready);
  assign ps_fire   = ps_valid && ps_ready;
  assign out_fire  = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the configuration registers are reset along with the datapath; the
  // block has no storage array, so a full reset costs nothing extra.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      passes_q    <= '0;
      outputs_q   <= '0;
      pass_cnt_q  <= '0;
      out_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Drain on handshake; a load below overrides this in the same cycle.
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            passes_q   <= passes_eff;
            outputs_q  <= outputs_eff;
            pass_cnt_q <= '0;
            out_cnt_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (ps_fire) begin
            if (sat_hit) begin
              ovf_q <= 1'b1;
            end
            if (last_pass) begin
              out_data_q  <= acc_sat;
              out_valid_q <= 1'b1;
              out_last_q  <= last_out;
              acc_q       <= '0;
              pass_cnt_q  <= '0;
              out_cnt_q   <= out_cnt_q + CNT_W'(1);
              if (last_out) begin
                state_q <= ST_FLUSH;
              end
            end else begin
              acc_q      <= acc_sat;
              pass_cnt_q <= pass_cnt_q + PASS_W'(1);
            end
          end
        end

        ST_FLUSH: begin
          if (out_fire) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_final_add_seq.sv
// ---------------------------------------------------------------------------
// tb_final_add_seq -- self-checking bench for final_add_seq (ACC_W = 16).
// A job-level model computes every expected word from the beat list and
// pushes it into a scoreboard; a monitor pops and compares on each output
// handshake and also watches back-pressure behaviour.
// ---------------------------------------------------------------------------
module tb_final_add_seq;
  localparam int PASS_W = 8;
  localparam int CNT_W  = 12;
  localparam int ACC_W  = 16;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic [CNT_W-1:0]  cfg_outputs = '0;
  logic              ps_valid = 1'b0;
  logic              ps_ready;
  logic [27:0]       ps_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              ovf;

  final_add_seq #(.PASS_W(PASS_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_passes  (cfg_passes),
    .cfg_outputs (cfg_outputs),
    .ps_valid    (ps_valid),
    .ps_ready    (ps_ready),
    .ps_data     (ps_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  int   bq_a[$];
  int   bq_b[$];
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: one stall burst
  int   stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: inputs change only just after posedge, so at negedge the values
  // seen are the ones the next posedge will act on.
  initial begin
    exp_t             e;
    logic [ACC_W-1:0] hd;
    logic             hl;
    bit               held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hd);
          check("hold_last", out_last, hl);
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got word %0d expected none", out_data);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
          end
        end else if (out_valid) begin
          check("stall_ps_ready", ps_ready, 0);
          held = 1'b1;
          hd   = out_data;
          hl   = out_last;
        end
      end
    end
  end

  function automatic logic [27:0] pack(input int a, input int b);
    logic [13:0] av;
    logic [13:0] bv;
    logic [27:0] d;
    av = a[13:0];
    bv = b[13:0];
    for (int k = 0; k < 14; k++) begin
      d[2*k]   = av[k];
      d[2*k+1] = bv[k];
    end
    return d;
  endfunction

  task automatic send_beat(input int a, input int b, input bit b2b);
    bit got;
    ps_data  = pack(a, b);
    ps_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (b2b && i == 0) check("ps_ready_b2b", ps_ready, 1);
      if (ps_ready) got = 1'b1;
    end
    if (!got) check("beat_timeout", got, 1);
    @(posedge clk);
    #1;
    ps_valid = 1'b0;
    ps_data  = 28'($urandom);
  endtask

  // Runs a whole job; beats come from bq_a/bq_b, topped up with random ones.
  task automatic run_job(input int pcfg, input int ocfg, input bit gaps,
                         input bit b2b, output int lat);
    int     pe, oe, nb, idx;
    longint total;
    bit     ovf_exp, got;
    exp_t   e;
    pe = (pcfg == 0) ? 1 : pcfg;
    oe = (ocfg == 0) ? 1 : ocfg;
    nb = pe * oe;
    while (bq_a.size() < nb) begin
      bq_a.push_back(int'($urandom_range(0, 16383)));
      bq_b.push_back(int'($urandom_range(0, 16383)));
    end
    ovf_exp = 1'b0;
    for (int w = 0; w < oe; w++) begin
      total = 0;
      for (int p = 0; p < pe; p++) begin
        idx = w * pe + p;
        total += (bq_a[idx] + bq_b[idx]) % 16384;
      end
      if (total > MAXV) ovf_exp = 1'b1;
      e.data = (total > MAXV) ? ACC_W'(MAXV) : ACC_W'(total);
      e.last = (w == oe - 1);
      sb_q.push_back(e);
    end

    cfg_passes  = PASS_W'(pcfg);
    cfg_outputs = CNT_W'(ocfg);
    cfg_start   = 1'b1;
    @(posedge clk);
    #1;
    cfg_start   = 1'b0;
    cfg_passes  = PASS_W'($urandom);
    cfg_outputs = CNT_W'($urandom);
    check("start_busy", busy, 1);
    check("start_ps_ready", ps_ready, 1);
    check("start_ovf_clear", ovf, 0);

    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ps_valid  = 1'b0;
        ps_data   = 28'($urandom);
        // A start while busy must be ignored, including its configuration.
        cfg_start = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
      end
      send_beat(bq_a[i], bq_b[i], b2b);
    end

    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    check("done_seen", got, 1);
    check("done_busy_low", busy, 0);
    check("done_ovf", ovf, ovf_exp);
    check("done_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    @(posedge clk);
    #1;
    bq_a.delete();
    bq_b.delete();
  endtask

  initial begin
    int lat;
    int sums[6];

    // Reset state.
    #12;
    check("rst_ps_ready", ps_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pass: 100 + 23, word next cycle, done the cycle after.
    rdy_mode = 0;
    bq_a.push_back(100);
    bq_b.push_back(23);
    run_job(1, 1, 1'b0, 1'b1, lat);
    check("single_done_latency", lat, 1);

    // Accumulation: sums 10,20,30 then 1,2,3 back-to-back.
    sums = '{10, 20, 30, 1, 2, 3};
    foreach (sums[i]) begin
      bq_a.push_back(sums[i] / 2);
      bq_b.push_back(sums[i] - sums[i] / 2);
    end
    run_job(3, 2, 1'b0, 1'b1, lat);

    // Adder wrap: 0x3FFF + 0x3FFF drops the carry, no clamp.
    bq_a.push_back(16383);
    bq_b.push_back(16383);
    run_job(1, 1, 1'b0, 1'b0, lat);

    // Back-pressure: four stalled cycles after the first word.
    rdy_mode   = 2;
    stall_left = 4;
    for (int i = 0; i < 3; i++) begin
      bq_a.push_back(1000 * (i + 1));
      bq_b.push_back(i + 7);
    end
    run_job(1, 3, 1'b0, 1'b0, lat);
    rdy_mode = 0;

    // Saturation: 5 x 16383 clamps at 65535 and ovf stays set.
    for (int i = 0; i < 5; i++) begin
      bq_a.push_back(16383);
      bq_b.push_back(0);
    end
    run_job(5, 1, 1'b0, 1'b1, lat);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", ovf, 1);

    // Reset mid-job after 2 of 3 passes.
    cfg_passes  = 8'd3;
    cfg_outputs = 12'd1;
    cfg_start   = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    send_beat(1000, 0, 1'b0);
    send_beat(2000, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ps_ready", ps_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    bq_a = '{7, 8, 9};
    bq_b = '{0, 0, 0};
    run_job(3, 1, 1'b0, 1'b1, lat);

    // Zero configuration means one pass, one word.
    run_job(0, 0, 1'b0, 1'b0, lat);

    // Throughput: final-pass beats landing on the previous word's handshake.
    run_job(1, 4, 1'b0, 1'b1, lat);

    // Randomized jobs with gaps, stray starts and random back-pressure.
    rdy_mode = 1;
    for (int j = 0; j < 40; j++) begin
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 1'b1, 1'b0, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
